// File: rtl/number_extractor.sv
// Decimal token extractor fed by a 12-stage character window.
// A token is an opening whitespace at the oldest stage, a run of digits and
// a whitespace terminator, all visible in the window at once. The digits are
// then accumulated one per en cycle as they reach the oldest stage.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | scanning each en cycle for an opening whitespace plus a digit run
// S_COLLECT | folding each digit at stage 11 into the accumulator
module number_extractor #(
  parameter int MAX_DIGITS = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  data_in,
  input  logic [11:0] is_number_in,
  input  logic [11:0] is_white_in,
  output logic [31:0] value,
  output logic [3:0]  digits,
  output logic        value_valid,
  output logic        token_drop,
  output logic        error,
  output logic [15:0] token_count
);

  localparam logic [3:0] LP_MAX = 4'(MAX_DIGITS);

  typedef enum logic {
    S_IDLE,
    S_COLLECT
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_acc;
  logic [3:0]  r_remaining;
  logic [3:0]  r_len;
  logic [31:0] r_value;
  logic [3:0]  r_digits;
  logic        r_value_valid;
  logic        r_token_drop;
  logic        r_error;
  logic [15:0] r_token_count;

  logic [3:0]  w_run_len;
  logic        w_run_stop;
  logic        w_term_white;
  logic        w_conflict;
  logic        w_len_ok;
  logic        w_detect;
  logic        w_drop;
  logic [7:0]  w_digit;
  logic [31:0] w_acc_mac;
  logic        w_load;
  logic        w_step;
  logic        w_done;
  logic        w_err;
  logic        w_drop_pulse;

  // Length of the digit run starting just after the opening byte (bit 10 down).
  always_comb begin
    w_run_len  = '0;
    w_run_stop = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      if (!w_run_stop && is_number_in[i]) begin
        w_run_len = w_run_len + 4'd1;
      end else begin
        w_run_stop = 1'b1;
      end
    end
  end

  // Terminator class and flag conflicts over the run plus its terminator.
  always_comb begin
    w_term_white = 1'b0;
    w_conflict   = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i == 10 - int'(w_run_len)) begin
        w_term_white = is_white_in[i];
      end
      if (i >= 10 - int'(w_run_len)) begin
        w_conflict = w_conflict | (is_number_in[i] & is_white_in[i]);
      end
    end
  end

  assign w_len_ok  = (w_run_len >= 4'd1) && (w_run_len <= LP_MAX);
  assign w_detect  = is_white_in[11] && w_len_ok && w_term_white && !w_conflict;
  // A run filling the whole window (L=11) has no visible terminator but is
  // already too long for any legal MAX_DIGITS, so it is dropped as well.
  assign w_drop    = is_white_in[11] && (w_run_len > LP_MAX) &&
                     ((w_run_len == 4'd11) || w_term_white) && !w_conflict;

  assign w_digit   = data_in - 8'h30;
  assign w_acc_mac = (r_acc * 32'd10) + {24'd0, w_digit};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath control; nothing advances while en is low.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    w_drop_pulse = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          if (w_detect) begin
            w_load       = 1'b1;
            w_state_next = S_COLLECT;
          end else if (w_drop) begin
            w_drop_pulse = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (en) begin
          if (is_number_in[11]) begin
            w_step = 1'b1;
            if (r_remaining == 4'd1) begin
              w_done       = 1'b1;
              w_state_next = S_IDLE;
            end
          end else begin
            w_err        = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Accumulator, result registers, event pulses and the token counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc         <= '0;
      r_remaining   <= '0;
      r_len         <= '0;
      r_value       <= '0;
      r_digits      <= '0;
      r_value_valid <= 1'b0;
      r_token_drop  <= 1'b0;
      r_error       <= 1'b0;
      r_token_count <= '0;
    end else begin
      r_value_valid <= w_done;
      r_token_drop  <= w_drop_pulse;
      r_error       <= w_err;
      if (w_load) begin
        r_acc       <= '0;
        r_remaining <= w_run_len;
        r_len       <= w_run_len;
      end else if (w_step) begin
        r_acc       <= w_acc_mac;
        r_remaining <= r_remaining - 4'd1;
      end else if (w_err) begin
        r_acc       <= '0;
        r_remaining <= '0;
      end
      if (w_done) begin
        r_value  <= w_acc_mac;
        r_digits <= r_len;
        if (r_token_count != 16'hFFFF) begin
          r_token_count <= r_token_count + 16'd1;
        end
      end
    end
  end

  assign value       = r_value;
  assign digits      = r_digits;
  assign value_valid = r_value_valid;
  assign token_drop  = r_token_drop;
  assign error       = r_error;
  assign token_count = r_token_count;

endmodule

// File: tb/tb_number_extractor.sv
// Bench for number_extractor: models the upstream 12-stage character window,
// queues the expected events per stream and checks them as pulses appear.
module tb_number_extractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  data_in;
  logic [11:0] is_number_in;
  logic [11:0] is_white_in;
  logic [31:0] value;
  logic [3:0]  digits;
  logic        value_valid;
  logic        token_drop;
  logic        error;
  logic [15:0] token_count;

  number_extractor #(.MAX_DIGITS(9)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .data_in      (data_in),
    .is_number_in (is_number_in),
    .is_white_in  (is_white_in),
    .value        (value),
    .digits       (digits),
    .value_valid  (value_valid),
    .token_drop   (token_drop),
    .error        (error),
    .token_count  (token_count)
  );

  always #5 clk = ~clk;

  // kind: 0 = value_valid, 1 = token_drop, 2 = error
  typedef struct {
    int          kind;
    logic [31:0] val;
    logic [3:0]  dig;
    logic [15:0] tc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  win [12];
  logic [7:0]  pend[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_tc = '0;
  logic        force_nn = 1'b0;
  exp_t        mon_e;
  int          mon_k;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_window();
    data_in = win[11];
    for (int i = 0; i < 12; i++) begin
      is_number_in[i] = (win[i] >= 8'h30) && (win[i] <= 8'h39);
      is_white_in[i]  = (win[i] == 8'h20);
    end
    if (force_nn) is_number_in[11] = 1'b0;
  endtask

  // One clock; when en is high the upstream window shifts on the same edge.
  task automatic cycle(input logic e);
    en = e;
    @(posedge clk);
    #1;
    if (e) begin
      for (int i = 11; i > 0; i--) win[i] = win[i-1];
      win[0] = (pend.size() > 0) ? pend.pop_front() : 8'h2e;
    end
    apply_window();
  endtask

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) pend.push_back(s[i]);
  endtask

  task automatic push_valid(input logic [31:0] v, input logic [3:0] d);
    exp_t e;
    exp_tc = exp_tc + 16'd1;
    e = '{0, v, d, exp_tc};
    sb.push_back(e);
  endtask

  task automatic push_kind(input int k);
    exp_t e;
    e = '{k, 32'd0, 4'd0, 16'd0};
    sb.push_back(e);
  endtask

  task automatic run_stream(input string s, input bit rnd);
    int n;
    logic e;
    n = 0;
    load(s);
    for (int k = 0; k < 2000 && n < s.len() + 12; k++) begin
      e = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle(e);
      if (e) n++;
    end
    cycle(1'b0);
  endtask

  task automatic advance_to_open();
    for (int k = 0; k < 40 && win[11] != 8'h20; k++) cycle(1'b1);
    check("open_reached", {24'd0, win[11]}, 32'h20);
  endtask

  task automatic flush_all();
    for (int k = 0; k < 200 && pend.size() > 0; k++) cycle(1'b1);
    repeat (12) cycle(1'b1);
    cycle(1'b0);
  endtask

  task automatic post(input string tag);
    check({tag, "_drained"}, sb.size(), 0);
    check({tag, "_count"}, {16'd0, token_count}, {16'd0, exp_tc});
  endtask

  // Scoreboard consumer: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (value_valid === 1'b1 || token_drop === 1'b1 || error === 1'b1) begin
      check("one_pulse", 32'($countones({value_valid, token_drop, error})), 32'd1);
      mon_k = (value_valid === 1'b1) ? 0 : (token_drop === 1'b1) ? 1 : 2;
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_pulse observed kind=%0d expected no event", mon_k);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("event_kind", mon_k, mon_e.kind);
        if (mon_e.kind == 0) begin
          check("value", value, mon_e.val);
          check("digits", {28'd0, digits}, {28'd0, mon_e.dig});
          check("token_count", {16'd0, token_count}, {16'd0, mon_e.tc});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    for (int i = 0; i < 12; i++) win[i] = 8'h2e;
    apply_window();
    repeat (2) @(posedge clk);
    #1;
    check("rst_value", value, 32'd0);
    check("rst_digits", {28'd0, digits}, 32'd0);
    check("rst_valid", {31'd0, value_valid}, 32'd0);
    check("rst_drop", {31'd0, token_drop}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_count", {16'd0, token_count}, 32'd0);
    rst = 1'b0;

    push_valid(32'd42, 4'd2);
    run_stream(" 42 ", 1'b0);
    post("t42");
    check("t42_value", value, 32'd42);

    push_valid(32'd123456789, 4'd9);
    run_stream(" 123456789 ", 1'b0);
    post("t9dig");

    push_kind(1);
    run_stream(" 1234567890 ", 1'b0);
    post("t10dig");
    check("t10dig_value_kept", value, 32'd123456789);

    run_stream(" 12a ", 1'b0);
    post("t12a");
    check("t12a_value_kept", value, 32'd123456789);

    push_valid(32'd0, 4'd1);
    run_stream(" 0 ", 1'b0);
    post("t0");

    push_valid(32'd7, 4'd1);
    push_valid(32'd8, 4'd1);
    run_stream(" 7 8 ", 1'b0);
    post("t78");

    push_valid(32'd7, 4'd1);
    push_valid(32'd8, 4'd1);
    run_stream(" 7 8 ", 1'b1);
    post("t78_rnd");

    push_valid(32'd305, 4'd3);
    push_valid(32'd61, 4'd2);
    run_stream(" 305 61 ", 1'b1);
    post("t305_61_rnd");

    // Digit flag dropped mid-collection.
    load(" 555 ");
    advance_to_open();
    cycle(1'b1);
    cycle(1'b1);
    force_nn = 1'b1;
    apply_window();
    push_kind(2);
    cycle(1'b1);
    force_nn = 1'b0;
    apply_window();
    flush_all();
    post("terr");
    check("terr_value_kept", value, 32'd61);
    check("terr_digits_kept", {28'd0, digits}, 32'd2);

    push_valid(32'd9, 4'd1);
    run_stream(" 9 ", 1'b0);
    post("t9_after_err");

    // Reset in the middle of a token.
    load(" 555 ");
    advance_to_open();
    cycle(1'b1);
    cycle(1'b1);
    rst = 1'b1;
    cycle(1'b1);
    check("midrst_value", value, 32'd0);
    check("midrst_digits", {28'd0, digits}, 32'd0);
    check("midrst_count", {16'd0, token_count}, 32'd0);
    check("midrst_pulses", {29'd0, value_valid, token_drop, error}, 32'd0);
    rst = 1'b0;
    exp_tc = '0;
    flush_all();
    post("tmidrst");
    check("tmidrst_value", value, 32'd0);

    push_valid(32'd31, 4'd2);
    run_stream(" 31 ", 1'b0);
    post("t31");
    check("t31_value", value, 32'd31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/number_extractor.md
NUMBER_EXTRACTOR -- requirements
Module: number_extractor

Interface
REQ-001 Parameter: MAX_DIGITS, default 9, longest accepted token in digits (legal range 1..9).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  shift enable; the same signal that advances the 12-stage character window feeding this block.
REQ-005 data_in  input  8  ASCII byte currently at window stage 11 (oldest byte).
REQ-006 is_number_in  input  12  per-stage digit flag; bit 11 is the oldest byte and corresponds to data_in.
REQ-007 is_white_in  input  12  per-stage whitespace flag; same bit ordering as is_number_in.
REQ-008 value  output  32  decimal value of the last completed token.
REQ-009 digits  output  4  digit count of the last completed token.
REQ-010 value_valid  output  1  one-cycle pulse; value and digits are valid.
REQ-011 token_drop  output  1  one-cycle pulse; token rejected as longer than MAX_DIGITS.
REQ-012 error  output  1  one-cycle pulse; a collected byte was not a digit.
REQ-013 token_count  output  16  number of value_valid pulses since reset, saturating at 16'hFFFF.

Function
REQ-014 The block shall implement two states, IDLE and COLLECT; no state or output other than the pulses shall change in a cycle with en low.
REQ-015 In IDLE with en high, the block shall compute L = number of consecutive set is_number_in bits from bit 10 downward.
REQ-016 A token shall be detected only when is_white_in[11]=1, 1<=L<=MAX_DIGITS, and is_white_in[10-L]=1.
REQ-017 A window with is_white_in[11]=1, L>MAX_DIGITS, and a whitespace terminator at bit 10-L (or L=11) shall pulse token_drop and leave the state at IDLE.
REQ-018 A window with a terminator that is neither whitespace nor a digit, or with any bit having both flags set in 10..10-L, shall not be detected and produces no pulse.
REQ-019 On detection the block shall load remaining=L and acc=0 and enter COLLECT.
REQ-020 In COLLECT with en high and is_number_in[11]=1, the block shall update acc = acc*10 + (data_in - 8'h30) and decrement remaining.
REQ-021 The accumulator arithmetic shall be 32-bit unsigned; overflow is impossible for MAX_DIGITS<=9.
REQ-022 When remaining reaches 0, the block shall register value=final acc and digits=L, pulse value_valid in the following cycle, increment token_count, and return to IDLE.
REQ-023 In COLLECT with en high and is_number_in[11]=0, the block shall pulse error, discard acc, and return to IDLE with value and digits unchanged.
REQ-024 The closing whitespace of a token shall be usable as the opening whitespace of the next token, giving back-to-back detection with no lost token.
REQ-025 Latency shall be L+1 en cycles from the detecting en cycle to the value_valid pulse, plus one clk cycle.
REQ-026 value_valid, token_drop and error shall each be high for exactly one clk cycle per event, and at most one of them shall be high in any cycle.

Reset
REQ-027 When rst=1 at a clock edge, the block shall set the state to IDLE, and set acc, remaining, value, digits, token_count, value_valid, token_drop and error to 0.
REQ-028 Reset shall take priority over en, and a token interrupted by reset shall produce no pulse.

Verification
REQ-029 Stream " 42 " with en=1 every cycle -> one value_valid with value=42, digits=2, token_count=1.
REQ-030 Stream " 123456789 " -> value=123456789, digits=9; " 1234567890 " -> token_drop pulse, no value_valid.
REQ-031 Stream " 12a " -> no value_valid, no token_drop, no error; token_count unchanged.
REQ-032 Stream " 7 8 " -> two value_valid pulses, value 7 then 8, token_count=2; en toggled 0/1 randomly -> same results.
REQ-033 rst asserted for one cycle mid-COLLECT of " 555 " -> all outputs 0 next cycle, no value_valid for that token.
REQ-034 Force is_number_in[11]=0 during COLLECT -> one error pulse, state IDLE, value unchanged.
